// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI constants and FSM state type for the axi_wb_master traffic generator
package axi_pkg;
    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_ID_W   = 4;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    typedef enum logic [2:0] {ST_IDLE, ST_WR, ST_WRESP, ST_RD, ST_RDATA, ST_DONE} state_t;
endpackage

// File: rtl/axi_wb_master_if.sv
// axi_wb_master_if: single-beat AXI4 bus bundle; master drives AW/W/AR and B/R readies, slave the rest
interface axi_wb_master_if;
    import axi_pkg::*;
    logic [AXI_ADDR_W-1:0] awaddr;
    logic [7:0]            awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic [AXI_ID_W-1:0]   awid;
    logic                  awvalid;
    logic                  awready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [7:0]            wstrb;
    logic                  wlast;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [AXI_ADDR_W-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [AXI_ID_W-1:0]   arid;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic                  rvalid;
    logic                  rready;
    modport master (
        output awaddr, awlen, awsize, awburst, awid, awvalid,
        output wdata, wstrb, wlast, wvalid, bready,
        output araddr, arlen, arsize, arburst, arid, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  awaddr, awlen, awsize, awburst, awid, awvalid,
        input  wdata, wstrb, wlast, wvalid, bready,
        input  araddr, arlen, arsize, arburst, arid, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_wb_pattern.sv
// axi_wb_pattern: address and expected data of transaction i
//   i_idx  transaction index
//   o_addr ADDR_BASE + 8*i
//   o_data {~lo, lo} with lo = DATA_SEED + i
module axi_wb_pattern
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter logic [31:0] DATA_SEED = 32'h1234_5678
) (
    input  logic [7:0]            i_idx,
    output logic [AXI_ADDR_W-1:0] o_addr,
    output logic [AXI_DATA_W-1:0] o_data
);
    logic [31:0] w_lo;
    assign w_lo   = DATA_SEED + {24'd0, i_idx};
    assign o_addr = ADDR_BASE + {21'd0, i_idx, 3'd0};
    assign o_data = {~w_lo, w_lo};
endmodule

// File: rtl/axi_wb_master.sv
// axi_wb_master: self-checking AXI4 write/read-back traffic generator
//   clk, reset     clock, synchronous active-high reset
//   start          pulse; starts a run from IDLE or DONE
//   m              AXI4 master port (single-beat INCR, 8-byte beats)
//   done, pass     run complete; pass iff no errors
//   err_cnt        saturating error count
//   first_err_addr address of the first failing transaction
// Define AXI_WB_READY_STALL_EN to hold bready/rready low for STALL_CYCLES after each response phase opens.
module axi_wb_master
    import axi_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
    parameter int          NUM_TXN      = 4,
    parameter logic [31:0] DATA_SEED    = 32'h1234_5678,
    parameter int          STALL_CYCLES = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    axi_wb_master_if.master       m,
    output logic                  done,
    output logic                  pass,
    output logic [7:0]            err_cnt,
    output logic [AXI_ADDR_W-1:0] first_err_addr
);
`ifdef AXI_WB_READY_STALL_EN
    localparam logic STALL_EN = 1'b1;
`else
    localparam logic STALL_EN = 1'b0;
`endif
    localparam logic [3:0] STALL_LOAD = STALL_EN ? 4'(STALL_CYCLES) : 4'd0;

    state_t                r_state, w_state_next;
    logic [7:0]            r_idx, r_err_cnt;
    logic                  r_act, r_aw_done, r_w_done;
    logic [3:0]            r_stall;
    logic [AXI_ADDR_W-1:0] r_first_err_addr, w_addr;
    logic [AXI_DATA_W-1:0] w_data;
    logic                  w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs, w_last, w_err, w_start;

    axi_wb_pattern #(.ADDR_BASE(ADDR_BASE), .DATA_SEED(DATA_SEED)) u_pat (
        .i_idx (r_idx),
        .o_addr(w_addr),
        .o_data(w_data)
    );

    // r_act is low for one bubble cycle after every phase change except the start of a run.
    always_comb begin
        w_state_next = r_state;
        m.awvalid = (r_state == ST_WR) && r_act && !r_aw_done;
        m.wvalid  = (r_state == ST_WR) && r_act && !r_w_done;
        m.bready  = (r_state == ST_WRESP) && r_act && (r_stall == 4'd0);
        m.arvalid = (r_state == ST_RD) && r_act;
        m.rready  = (r_state == ST_RDATA) && r_act && (r_stall == 4'd0);
        w_aw_hs = m.awvalid && m.awready;
        w_w_hs  = m.wvalid && m.wready;
        w_b_hs  = m.bvalid && m.bready;
        w_ar_hs = m.arvalid && m.arready;
        w_r_hs  = m.rvalid && m.rready;
        w_last  = r_idx == 8'(NUM_TXN - 1);
        w_start = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && start;
        w_err   = (w_b_hs && (m.bresp != AXI_RESP_OKAY)) ||
                  (w_r_hs && ((m.rdata != w_data) || (m.rresp != AXI_RESP_OKAY) || !m.rlast));
        unique case (r_state)
            ST_IDLE, ST_DONE: w_state_next = start ? ST_WR : r_state;
            ST_WR:    w_state_next = ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) ? ST_WRESP : ST_WR;
            ST_WRESP: w_state_next = w_b_hs ? ST_RD : ST_WRESP;
            ST_RD:    w_state_next = w_ar_hs ? ST_RDATA : ST_RD;
            ST_RDATA: w_state_next = w_r_hs ? (w_last ? ST_DONE : ST_WR) : ST_RDATA;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state          <= ST_IDLE;
            r_idx            <= 8'd0;
            r_act            <= 1'b0;
            r_aw_done        <= 1'b0;
            r_w_done         <= 1'b0;
            r_stall          <= 4'd0;
            r_err_cnt        <= 8'd0;
            r_first_err_addr <= '0;
        end else begin
            r_state   <= w_state_next;
            r_act     <= (w_state_next == r_state) || (r_state == ST_IDLE) || (r_state == ST_DONE);
            r_aw_done <= (r_state == ST_WR) && (r_aw_done || w_aw_hs);
            r_w_done  <= (r_state == ST_WR) && (r_w_done || w_w_hs);
            // Hold-off counts only once the bubble cycle has passed.
            r_stall   <= ((w_state_next != r_state) && ((w_state_next == ST_WRESP) || (w_state_next == ST_RDATA))) ? STALL_LOAD :
                         (r_act && (r_stall != 4'd0)) ? r_stall - 4'd1 : r_stall;
            if (w_start) begin
                r_idx            <= 8'd0;
                r_err_cnt        <= 8'd0;
                r_first_err_addr <= '0;
            end else begin
                if (w_r_hs && !w_last)
                    r_idx <= r_idx + 8'd1;
                if (w_err) begin
                    r_err_cnt <= (r_err_cnt == 8'hFF) ? r_err_cnt : r_err_cnt + 8'd1;
                    if (r_err_cnt == 8'd0)
                        r_first_err_addr <= w_addr;
                end
            end
        end
    end

    // Payloads are zero when idle and held stable while their valid is up.
    assign m.awaddr  = m.awvalid ? w_addr : '0;
    assign m.wdata   = m.wvalid ? w_data : '0;
    assign m.araddr  = m.arvalid ? w_addr : '0;
    assign m.awlen   = 8'd0;
    assign m.awsize  = AXI_SIZE_8B;
    assign m.awburst = AXI_BURST_INCR;
    assign m.awid    = '0;
    assign m.arlen   = 8'd0;
    assign m.arsize  = AXI_SIZE_8B;
    assign m.arburst = AXI_BURST_INCR;
    assign m.arid    = '0;
    assign m.wstrb   = 8'hFF;
    assign m.wlast   = m.wvalid;

    assign done           = r_state == ST_DONE;
    assign pass           = done && (r_err_cnt == 8'd0);
    assign err_cnt        = r_err_cnt;
    assign first_err_addr = r_first_err_addr;
endmodule
